// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: walks a PC through a 1-cycle-latency instruction memory,
// buffers returned words in a 2-entry FIFO and hands them downstream over valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_halt_req,
    input  logic [ADDR_W:0]   i_prog_len,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_ir_out,
    output logic [ADDR_W-1:0] o_ir_pc,
    output logic              o_ir_illegal,
    output logic              o_ir_valid,
    input  logic              i_ir_ready,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              r_state;
    logic [ADDR_W:0]     r_pc;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                r_inflight;
    logic                r_busy;
    logic                r_done;
    logic [31:0]         r_fifo_data [2];
    logic [ADDR_W-1:0]   r_fifo_pc   [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [2:0]          w_occ_after_pop;
    logic [ADDR_W:0]     w_pc_next;

    // Occupancy the FIFO will have after this edge: the in-flight word lands, the head may leave.
    assign w_pop           = o_ir_valid && i_ir_ready;
    assign w_push          = r_inflight;
    assign w_occ_after_pop = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_pc_next       = r_pc + (ADDR_W+1)'(1);
    assign w_issue         = (r_state == FETCH) && !i_halt_req && (r_pc < r_len)
                             && (w_occ_after_pop < 3'd2);

    assign o_imem_en    = w_issue;
    assign o_imem_addr  = w_issue ? r_pc[ADDR_W-1:0] : r_last_addr;
    assign o_ir_valid   = (r_count != 2'd0);
    assign o_ir_out     = r_fifo_data[r_rd_ptr];
    assign o_ir_pc      = r_fifo_pc[r_rd_ptr];
    assign o_ir_illegal = o_ir_valid && (o_ir_out[31:27] > 5'b01011);
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_last_addr <= '0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= 1'b0;
            if (w_issue) begin
                r_pc        <= w_pc_next;
                r_last_addr <= r_pc[ADDR_W-1:0];
            end
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_len   <= i_prog_len;
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (i_prog_len == '0) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (i_halt_req || (w_issue && (w_pc_next == r_len))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_occ_after_pop == 3'd0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // r_last_addr still holds the address of the read whose data arrives now.
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= i_imem_rdata;
                r_fifo_pc[r_wr_ptr]   <= r_last_addr;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_occ_after_pop[1:0];
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural memory plus a negedge monitor logging
// reads, transfers and done pulses; each test task checks the log against hand-worked values.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        haltReq = 1'b0;
    logic [10:0] progLen = '0;
    logic        imemEn;
    logic [9:0]  imemAddr;
    logic [31:0] imemRdata = '0;
    logic [31:0] irOut;
    logic [9:0]  irPc;
    logic        irIllegal;
    logic        irValid;
    logic        irReady = 1'b0;
    logic        busy;
    logic        done;

    logic        start3 = 1'b0;
    logic [3:0]  progLen3 = '0;
    logic        en3;
    logic [2:0]  addr3;
    logic [31:0] rdata3 = '0;
    logic [31:0] irOut3;
    logic [2:0]  irPc3;
    logic        ill3;
    logic        valid3;
    logic        busy3;
    logic        done3;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int passes = 0;
    int nCyc = 0;
    int base = 0;

    int          enCyc[$];
    logic [9:0]  enAddr[$];
    int          xCyc[$];
    logic [9:0]  xPc[$];
    logic [31:0] xData[$];
    logic        xIll[$];
    int          doneCyc[$];

    instr_fetch_unit #(.ADDR_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(haltReq),
        .i_prog_len(progLen), .o_imem_en(imemEn), .o_imem_addr(imemAddr),
        .i_imem_rdata(imemRdata), .o_ir_out(irOut), .o_ir_pc(irPc),
        .o_ir_illegal(irIllegal), .o_ir_valid(irValid), .i_ir_ready(irReady),
        .o_busy(busy), .o_done(done)
    );

    instr_fetch_unit #(.ADDR_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_halt_req(1'b0),
        .i_prog_len(progLen3), .o_imem_en(en3), .o_imem_addr(addr3),
        .i_imem_rdata(rdata3), .o_ir_out(irOut3), .o_ir_pc(irPc3),
        .o_ir_illegal(ill3), .o_ir_valid(valid3), .i_ir_ready(1'b1),
        .o_busy(busy3), .o_done(done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imemEn) imemRdata <= mem[imemAddr];
        if (en3) rdata3 <= {5'b00001, 24'd0, addr3};
    end

    // Cycle k of a run is logged as base+k.
    always @(negedge clk) begin
        nCyc = nCyc + 1;
        if (imemEn) begin
            enCyc.push_back(nCyc);
            enAddr.push_back(imemAddr);
        end
        if (irValid && irReady) begin
            xCyc.push_back(nCyc);
            xPc.push_back(irPc);
            xData.push_back(irOut);
            xIll.push_back(irIllegal);
        end
        if (done) doneCyc.push_back(nCyc);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearLog();
        enCyc.delete(); enAddr.delete(); xCyc.delete(); xPc.delete();
        xData.delete(); xIll.delete(); doneCyc.delete();
    endtask

    task automatic fillMem(input logic [4:0] op);
        for (int i = 0; i < 32; i++) mem[i] = {op, 27'(i)};
    endtask

    task automatic startRun(input logic [10:0] len);
        @(posedge clk); #1;
        clearLog();
        base = nCyc + 1;
        progLen = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int i = 0; i < limit && doneCyc.size() == 0; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imemEn !== 1'b0) $display("[TB] FAIL reset_imem_en: got %b want 0", imemEn); else passes++;
        checks++; if (imemAddr !== 10'd0) $display("[TB] FAIL reset_imem_addr: got %0d want 0", imemAddr); else passes++;
        checks++; if (irOut !== 32'd0) $display("[TB] FAIL reset_ir_out: got %h want 0", irOut); else passes++;
        checks++; if (irPc !== 10'd0) $display("[TB] FAIL reset_ir_pc: got %0d want 0", irPc); else passes++;
        checks++; if (irIllegal !== 1'b0) $display("[TB] FAIL reset_ir_illegal: got %b want 0", irIllegal); else passes++;
        checks++; if (irValid !== 1'b0) $display("[TB] FAIL reset_ir_valid: got %b want 0", irValid); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        fillMem(5'b00010);
        irReady = 1'b1;
        startRun(11'd4);
        waitDone(40);
        checks++; if (xCyc.size() !== 4) $display("[TB] FAIL basic_count: got %0d want 4", xCyc.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= xCyc.size() || xPc[i] !== 10'(i) || xCyc[i] - base !== 3 + i
                || xData[i] !== {5'b00010, 27'(i)} || xIll[i] !== 1'b0)
                $display("[TB] FAIL basic_xfer%0d: got pc=%0d cyc=%0d data=%h ill=%b want pc=%0d cyc=%0d data=%h ill=0",
                         i, xPc[i], xCyc[i] - base, xData[i], xIll[i], i, 3 + i, {5'b00010, 27'(i)});
            else passes++;
        end
        checks++; if (enCyc.size() !== 4 || enCyc[0] - base !== 1 || enAddr[3] !== 10'd3)
            $display("[TB] FAIL basic_reads: got n=%0d first=%0d last_addr=%0d want 4/1/3", enCyc.size(), enCyc[0] - base, enAddr[3]);
        else passes++;
        checks++; if (doneCyc.size() !== 1 || doneCyc[0] - base !== 7)
            $display("[TB] FAIL basic_done: got n=%0d cyc=%0d want 1 at 7", doneCyc.size(), doneCyc[0] - base);
        else passes++;
        @(posedge clk); #1;
        checks++; if (imemEn !== 1'b0 || imemAddr !== 10'd3)
            $display("[TB] FAIL basic_addr_hold: got en=%b addr=%0d want 0/3", imemEn, imemAddr);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic stable;
        int stallEn;
        fillMem(5'b00011);
        irReady = 1'b0;
        startRun(11'd8);
        stable = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k >= 3 && (irValid !== 1'b1 || irOut !== {5'b00011, 27'd0} || irPc !== 10'd0)) stable = 1'b0;
        end
        @(posedge clk); #1;
        irReady = 1'b1;
        waitDone(60);
        stallEn = 0;
        foreach (enCyc[j]) if (enCyc[j] - base <= 10) stallEn++;
        checks++; if (stable !== 1'b1) $display("[TB] FAIL bp_stable: got head changed want head pc 0 held"); else passes++;
        checks++; if (stallEn !== 2) $display("[TB] FAIL bp_stall_reads: got %0d want 2", stallEn); else passes++;
        checks++; if (enAddr[0] !== 10'd0 || enAddr[1] !== 10'd1)
            $display("[TB] FAIL bp_stall_addrs: got %0d,%0d want 0,1", enAddr[0], enAddr[1]);
        else passes++;
        checks++; if (enCyc[2] - base !== 11) $display("[TB] FAIL bp_resume: got cycle %0d want 11", enCyc[2] - base); else passes++;
        checks++; if (xCyc.size() !== 8) $display("[TB] FAIL bp_count: got %0d want 8", xCyc.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= xPc.size() || xPc[i] !== 10'(i) || xData[i] !== {5'b00011, 27'(i)})
                $display("[TB] FAIL bp_xfer%0d: got pc=%0d data=%h want pc=%0d data=%h", i, xPc[i], xData[i], i, {5'b00011, 27'(i)});
            else passes++;
        end
    endtask

    task automatic test_illegal();
        logic expIll;
        fillMem(5'b00010);
        mem[1] = {5'b01011, 27'd1};
        mem[2] = {5'b01100, 27'd2};
        mem[3] = {5'b11111, 27'd3};
        irReady = 1'b1;
        startRun(11'd4);
        waitDone(40);
        checks++; if (xIll.size() !== 4) $display("[TB] FAIL ill_count: got %0d want 4", xIll.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            expIll = (i >= 2);
            checks++;
            if (i >= xIll.size() || xIll[i] !== expIll || xPc[i] !== 10'(i))
                $display("[TB] FAIL ill_flag%0d: got pc=%0d ill=%b want pc=%0d ill=%b", i, xPc[i], xIll[i], i, expIll);
            else passes++;
        end
    endtask

    task automatic test_halt();
        fillMem(5'b00100);
        irReady = 1'b1;
        startRun(11'd16);
        repeat (4) @(posedge clk);
        #1;
        haltReq = 1'b1;
        waitDone(40);
        haltReq = 1'b0;
        checks++; if (enCyc.size() !== 4 || enCyc[3] - base !== 4)
            $display("[TB] FAIL halt_reads: got n=%0d last=%0d want 4 last at 4", enCyc.size(), enCyc[3] - base);
        else passes++;
        checks++; if (xCyc.size() !== 4 || xPc[3] !== 10'd3)
            $display("[TB] FAIL halt_xfers: got n=%0d last_pc=%0d want 4/3", xCyc.size(), xPc[3]);
        else passes++;
        checks++; if (doneCyc.size() !== 1) $display("[TB] FAIL halt_done: got %0d pulses want 1", doneCyc.size()); else passes++;
    endtask

    task automatic test_zero_len();
        startRun(11'd0);
        waitDone(10);
        checks++; if (doneCyc.size() !== 1 || doneCyc[0] - base < 1 || doneCyc[0] - base > 2)
            $display("[TB] FAIL zero_done: got n=%0d cyc=%0d want 1 pulse by cycle 2", doneCyc.size(), doneCyc[0] - base);
        else passes++;
        checks++; if (enCyc.size() !== 0) $display("[TB] FAIL zero_reads: got %0d want 0", enCyc.size()); else passes++;
    endtask

    task automatic test_start_busy();
        fillMem(5'b00101);
        irReady = 1'b1;
        startRun(11'd6);
        repeat (2) @(posedge clk);
        #1;
        progLen = 11'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(40);
        checks++; if (xCyc.size() !== 6 || xPc[5] !== 10'd5)
            $display("[TB] FAIL busy_start_xfers: got n=%0d last_pc=%0d want 6/5", xCyc.size(), xPc[5]);
        else passes++;
        checks++; if (enCyc.size() !== 6 || doneCyc.size() !== 1)
            $display("[TB] FAIL busy_start_reads: got reads=%0d dones=%0d want 6/1", enCyc.size(), doneCyc.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        fillMem(5'b00110);
        irReady = 1'b0;
        startRun(11'd8);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (irValid !== 1'b1 || irPc !== 10'd0) $display("[TB] FAIL rmid_pre: got valid=%b pc=%0d want 1/0", irValid, irPc); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (irValid !== 1'b0 || irOut !== 32'd0 || irPc !== 10'd0 || irIllegal !== 1'b0)
            $display("[TB] FAIL rmid_ir: got valid=%b out=%h pc=%0d ill=%b want all 0", irValid, irOut, irPc, irIllegal);
        else passes++;
        checks++; if (imemEn !== 1'b0 || imemAddr !== 10'd0)
            $display("[TB] FAIL rmid_imem: got en=%b addr=%0d want 0/0", imemEn, imemAddr);
        else passes++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rmid_status: got busy=%b done=%b want 0/0", busy, done); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clearLog();
        irReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || enCyc.size() !== 0 || irValid !== 1'b0)
            $display("[TB] FAIL rmid_idle: got busy=%b reads=%0d valid=%b want 0/0/0", busy, enCyc.size(), irValid);
        else passes++;
        startRun(11'd3);
        waitDone(30);
        checks++; if (enAddr.size() !== 3 || enAddr[0] !== 10'd0)
            $display("[TB] FAIL rmid_refetch: got reads=%0d first=%0d want 3/0", enAddr.size(), enAddr[0]);
        else passes++;
        checks++; if (xCyc.size() !== 3 || xPc[0] !== 10'd0 || xPc[2] !== 10'd2 || xData[0] !== {5'b00110, 27'd0})
            $display("[TB] FAIL rmid_xfers: got n=%0d pc0=%0d pc2=%0d d0=%h want 3/0/2/%h", xCyc.size(), xPc[0], xPc[2], xData[0], {5'b00110, 27'd0});
        else passes++;
    endtask

    task automatic test_full_mem3();
        logic [2:0]  a3[$];
        logic [2:0]  p3[$];
        logic [31:0] d3[$];
        logic        gotDone;
        gotDone = 1'b0;
        @(posedge clk); #1;
        progLen3 = 4'd8;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 40 && !gotDone; i++) begin
            if (en3) a3.push_back(addr3);
            if (valid3) begin
                p3.push_back(irPc3);
                d3.push_back(irOut3);
            end
            if (done3) gotDone = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (gotDone !== 1'b1) $display("[TB] FAIL mem3_done: got no done want done"); else passes++;
        checks++; if (a3.size() !== 8 || p3.size() !== 8)
            $display("[TB] FAIL mem3_count: got reads=%0d xfers=%0d want 8/8", a3.size(), p3.size());
        else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= p3.size() || i >= a3.size() || a3[i] !== 3'(i) || p3[i] !== 3'(i)
                || d3[i] !== {5'b00001, 24'd0, 3'(i)})
                $display("[TB] FAIL mem3_word%0d: got addr=%0d pc=%0d data=%h want %0d/%0d/%h",
                         i, a3[i], p3[i], d3[i], i, i, {5'b00001, 24'd0, 3'(i)});
            else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_halt();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        test_full_mem3();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the execute/ALU stage. Walks a program counter through a synchronous instruction memory (1-cycle read latency), buffers returned words in a 2-entry FIFO, and presents them as a 32-bit instruction word over a valid/ready handshake. It also flags opcodes outside the implemented set (5'b00000–5'b01011), so the execute stage never sees an undefined `oper_type` unannounced.

## Interface
- `ADDR_W`, 10, instruction memory address width (PC width).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins fetching at address 0. Honoured only in IDLE or DONE.
- `halt_req`  in  1  level; stop issuing new reads, drain, then go to DONE.
- `prog_len`  in  ADDR_W+1  number of instructions to fetch; sampled on an accepted `start`.
- `imem_en`  out  1  memory read strobe.
- `imem_addr`  out  ADDR_W  read address (= current PC while `imem_en`).
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`.
- `ir_out`  out  32  FIFO head instruction word.
- `ir_pc`  out  ADDR_W  address from which `ir_out` was fetched.
- `ir_illegal`  out  1  `ir_out[31:27]` > 5'b01011. Qualified by `ir_valid`.
- `ir_valid`  out  1  FIFO non-empty.
- `ir_ready`  in  1  downstream accepts; transfer happens when `ir_valid && ir_ready`.
- `busy`  out  1  state is FETCH or DRAIN.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE + `start`: latch `prog_len` into `len_q`, PC := 0. Go to FETCH, or to DRAIN if `prog_len` = 0.
- FETCH issue rule: `imem_en` = 1 when PC < `len_q`, `halt_req` = 0, and (occupancy + inflight − pop) < 2. Here occupancy ∈ {0,1,2}, inflight ∈ {0,1} is a read issued last cycle, and pop = `ir_valid && ir_ready`. On issue, PC += 1.
- Returned word plus its address is pushed into the FIFO the cycle after issue. Push and pop in the same cycle is legal: occupancy stays the same, and head/tail pointers both advance.
- FETCH → DRAIN when the issue makes PC = `len_q`, or when `halt_req` is seen. No read is issued in the cycle `halt_req` is high.
- DRAIN: no reads. DRAIN → DONE when inflight = 0 and occupancy = 0, both after this cycle's pop.
- DONE: `done` pulses for one cycle. FIFO is empty. Holds until `start`.
- `start` while `busy` is ignored.
- PC is ADDR_W+1 bits internally, so `len_q` = 2^ADDR_W fetches the whole memory without wrap. `imem_addr` = PC[ADDR_W-1:0].
- `ir_out`, `ir_pc` and `ir_illegal` stay stable while `ir_valid && !ir_ready`.
- FIFO can never overflow: the issue rule guarantees it. Overflow is an assertion failure.

## Timing
- Reset (async): state IDLE, PC 0, `len_q` 0, FIFO pointers and occupancy 0, inflight 0, and every output 0 (`imem_en`, `imem_addr`, `ir_out`, `ir_pc`, `ir_illegal`, `ir_valid`, `busy`, `done`).
- Reset mid-operation aborts immediately and discards the in-flight read. After release, stay in IDLE until `start`.
- `start` sampled at edge 0. FETCH and first `imem_en` (addr 0) in cycle 1. Data is pushed at edge 2. `ir_valid` is high in cycle 2+1 = 3 cycles after `start`.
- With `ir_ready` held high: one instruction per cycle, no bubbles.
- With `ir_ready` low: at most 2 words buffered, then issue stalls. When `ready` rises, issue resumes in the same cycle.
- `done` is asserted the cycle after the last pop, or the cycle after `start` when `prog_len` = 0.
- `imem_addr` holds its last value when `imem_en` = 0.

## Test plan
- Basic stream: memory[i] = {5'b00010, i}, `prog_len` = 4, `ready` high → `ir_valid` from cycle 3, `ir_pc` 0,1,2,3 on consecutive cycles, `done` one cycle after the 4th transfer, no `ir_illegal`.
- Backpressure: `prog_len` = 8, `ready` low for cycles 3–10 → exactly 2 `imem_en` pulses (addr 0,1) while stalled, `ir_out` stable. After `ready` rises, all 8 words are delivered in order, no loss or duplication.
- Illegal opcode: memory[2] opcode 5'b01100, memory[3] opcode 5'b11111 → `ir_illegal` = 1 only with `ir_pc` 2 and 3. Opcode 5'b01011 at addr 1 → 0.
- Halt: `prog_len` = 16, `halt_req` asserted in cycle 5 → no `imem_en` from cycle 5, buffered and in-flight words delivered, then `done`. Number of transfers equals number of issued reads (4).
- Boundaries: `prog_len` = 0 → `done` one cycle after `start`, no `imem_en`. With ADDR_W = 3, `prog_len` = 8 → addrs 0..7, no wrap, `done`. `start` while busy is ignored.
- Reset mid-run: `rst_n` low in cycle 6 with 2 words buffered → all outputs 0 asynchronously. After release, a new `start` refetches from addr 0.
